// File: rtl/chroma_key_pkg.sv
// Shared types and helpers for the chroma-key controller and its pixel pipeline.
package chroma_key_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        CALIB,
        DONE
    } ck_state_t;

    localparam int EXCESS_W = 10;

    // Green excess g - r - b, held in 10-bit signed (-510..255).
    function automatic logic signed [EXCESS_W-1:0] green_excess(
        input logic [7:0] r,
        input logic [7:0] g,
        input logic [7:0] b
    );
        return $signed({2'b00, g} - {2'b00, r} - {2'b00, b});
    endfunction

endpackage

// File: rtl/chroma_key_pipe.sv
// Two-stage keying datapath: S1 registers the pixel and its green excess,
// S2 registers the pixel again together with the key mask.
module chroma_key_pipe
    import chroma_key_pkg::*;
(
    input  logic       gclk,
    input  logic       grst_n,
    input  logic       pix_valid,
    input  logic       pix_sof,
    input  logic [7:0] pix_r,
    input  logic [7:0] pix_g,
    input  logic [7:0] pix_b,
    input  logic [8:0] thresh,
    output logic       s1_sof,
    output logic       key_valid,
    output logic       key_sof,
    output logic [7:0] key_r,
    output logic [7:0] key_g,
    output logic [7:0] key_b,
    output logic       key_mask
);

    localparam int STAGES = 2;

    logic [STAGES:1]             vld_pipe;
    logic [STAGES:1]             sof_pipe;
    logic [7:0]                  r1, g1, b1;
    logic [7:0]                  r2, g2, b2;
    logic signed [EXCESS_W-1:0]  ex1;
    logic                        mask2;

    // Qualifiers shift every cycle; data registers follow unconditionally,
    // so payload on invalid cycles is simply stale.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            vld_pipe <= '0;
            sof_pipe <= '0;
            r1       <= '0;
            g1       <= '0;
            b1       <= '0;
            ex1      <= '0;
            r2       <= '0;
            g2       <= '0;
            b2       <= '0;
            mask2    <= 1'b1;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], pix_valid};
            sof_pipe <= {sof_pipe[STAGES-1:1], pix_valid & pix_sof};
            r1       <= pix_r;
            g1       <= pix_g;
            b1       <= pix_b;
            ex1      <= green_excess(pix_r, pix_g, pix_b);
            r2       <= r1;
            g2       <= g1;
            b2       <= b1;
            mask2    <= (ex1 > $signed({1'b0, thresh})) ? 1'b0 : 1'b1;
        end
    end

    assign s1_sof    = sof_pipe[1];
    assign key_valid = vld_pipe[STAGES];
    assign key_sof   = sof_pipe[STAGES];
    assign key_r     = r2;
    assign key_g     = g2;
    assign key_b     = b2;
    assign key_mask  = mask2;

endmodule

// File: rtl/chroma_key_controller.sv
// Green-screen key controller: runs the keying pipeline continuously and
// calibrates the key threshold from the first CAL_N pixels of a frame.
module chroma_key_controller
    import chroma_key_pkg::*;
#(
    parameter int CAL_LOG2       = 10,
    parameter int MARGIN         = 32,
    parameter int DEFAULT_THRESH = 64
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       calib_start_in,
    input  logic       pixel_valid_in,
    input  logic       frame_start_in,
    input  logic [7:0] r_in,
    input  logic [7:0] g_in,
    input  logic [7:0] b_in,
    output logic       pixel_valid_out,
    output logic       frame_start_out,
    output logic [7:0] r_out,
    output logic [7:0] g_out,
    output logic [7:0] b_out,
    output logic       mask_out,
    output logic [8:0] threshold_out,
    output logic       busy_out,
    output logic       cal_done_out
);

    localparam int ACC_W = EXCESS_W + CAL_LOG2;
    localparam int RAW_W = ACC_W + 1;
    localparam int CNT_W = CAL_LOG2 + 1;
    localparam int CAL_N = 1 << CAL_LOG2;

    ck_state_t                  state_q, state_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [7:0]                 shadow_q, shadow_d;
    logic [7:0]                 active_q;
    logic                       done_q, done_d;

    logic                       s1_sof;
    logic [8:0]                 thr_sel;
    logic signed [EXCESS_W-1:0] ex_in;
    logic signed [ACC_W-1:0]    ex_ext;
    logic signed [ACC_W-1:0]    mean_full;
    logic signed [RAW_W-1:0]    thr_raw;
    logic [7:0]                 thr_clamp;

    assign ex_in     = green_excess(r_in, g_in, b_in);
    assign ex_ext    = ACC_W'(ex_in);
    assign mean_full = acc_q >>> CAL_LOG2;
    assign thr_raw   = RAW_W'(mean_full) - RAW_W'(MARGIN);

    // Clamp mean minus margin into the 0..255 threshold range.
    always_comb begin
        thr_clamp = thr_raw[7:0];
        if (thr_raw[RAW_W-1])
            thr_clamp = 8'd0;
        else if (thr_raw > RAW_W'(255))
            thr_clamp = 8'd255;
    end

    // FSM, accumulator, sample counter and shadow threshold registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= 8'(DEFAULT_THRESH);
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            done_q   <= done_d;
        end
    end

    // Next state: the arming frame_start must arrive after the arm cycle,
    // and the first sample is the frame_start pixel itself.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (calib_start_in)
                    state_d = ARM;
            end
            ARM: begin
                if (pixel_valid_in && frame_start_in) begin
                    acc_d   = ex_ext;
                    cnt_d   = CNT_W'(1);
                    state_d = (CAL_N == 1) ? DONE : CALIB;
                end
            end
            CALIB: begin
                if (pixel_valid_in) begin
                    acc_d = acc_q + ex_ext;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(CAL_N - 1))
                        state_d = DONE;
                end
            end
            DONE: begin
                shadow_d = thr_clamp;
                done_d   = 1'b1;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Active threshold only changes as a frame's first pixel leaves S1.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            active_q <= 8'(DEFAULT_THRESH);
        else if (s1_sof)
            active_q <= shadow_q;
    end

    // The frame-start pixel itself is already compared against the new value.
    assign thr_sel = s1_sof ? {1'b0, shadow_q} : {1'b0, active_q};

    chroma_key_pipe u_pipe (
        .gclk      (clk_in),
        .grst_n    (rst_n_in),
        .pix_valid (pixel_valid_in),
        .pix_sof   (frame_start_in),
        .pix_r     (r_in),
        .pix_g     (g_in),
        .pix_b     (b_in),
        .thresh    (thr_sel),
        .s1_sof    (s1_sof),
        .key_valid (pixel_valid_out),
        .key_sof   (frame_start_out),
        .key_r     (r_out),
        .key_g     (g_out),
        .key_b     (b_out),
        .key_mask  (mask_out)
    );

    assign threshold_out = {1'b0, active_q};
    assign busy_out      = (state_q == ARM) || (state_q == CALIB);
    assign cal_done_out  = done_q;

endmodule
